// File: rtl/grf_wb_pkg.sv
// Shared types and constants for the GRF write-back arbiter.
package grf_wb_pkg;

    localparam int DEFAULT_DEPTH = 4;

    // Writes to r0 are architecturally discarded.
    localparam logic [4:0] REG_ZERO = 5'd0;

    typedef struct packed {
        logic [31:0] pc;
        logic [4:0]  addr;
        logic [31:0] data;
    } wb_entry_t;

    // True when a destination address produces a real register write.
    function automatic logic is_live(input logic [4:0] addr);
        return addr != REG_ZERO;
    endfunction

endpackage

// File: rtl/grf_wb_if.sv
// Bundle of producer handshakes, GRF write port and decode lookups.
interface grf_wb_if
    import grf_wb_pkg::*;
#(
    parameter int DEPTH = DEFAULT_DEPTH
);
    localparam int CW = $clog2(DEPTH + 1);

    // Port 0: single-cycle ALU/load results
    logic        in0_valid;
    logic        in0_ready;
    logic [31:0] in0_pc;
    logic [4:0]  in0_addr;
    logic [31:0] in0_data;

    // Port 1: multi-cycle unit completions
    logic        in1_valid;
    logic        in1_ready;
    logic [31:0] in1_pc;
    logic [4:0]  in1_addr;
    logic [31:0] in1_data;

    // GRF write port
    logic [31:0] PC;
    logic [4:0]  A3;
    logic [31:0] WD;
    logic        WE;

    // Decode-stage lookups
    logic [4:0]  rd_a1;
    logic [4:0]  rd_a2;
    logic        hit1;
    logic        hit2;
    logic [31:0] fwd1;
    logic [31:0] fwd2;

    // Occupancy status
    logic [CW-1:0] count;
    logic          full;
    logic          empty;

    modport master (
        output in0_valid, in0_pc, in0_addr, in0_data,
        output in1_valid, in1_pc, in1_addr, in1_data,
        output rd_a1, rd_a2,
        input  in0_ready, in1_ready,
        input  PC, A3, WD, WE,
        input  hit1, hit2, fwd1, fwd2,
        input  count, full, empty
    );

    modport slave (
        input  in0_valid, in0_pc, in0_addr, in0_data,
        input  in1_valid, in1_pc, in1_addr, in1_data,
        input  rd_a1, rd_a2,
        output in0_ready, in1_ready,
        output PC, A3, WD, WE,
        output hit1, hit2, fwd1, fwd2,
        output count, full, empty
    );

endinterface

// File: rtl/grf_wb_match.sv
// Youngest-match search over the occupied queue entries for one lookup port.
module grf_wb_match
    import grf_wb_pkg::*;
#(
    parameter  int DEPTH = DEFAULT_DEPTH,
    localparam int PW    = $clog2(DEPTH),
    localparam int CW    = $clog2(DEPTH + 1)
) (
    input  logic [DEPTH-1:0][4:0]  addrs,
    input  logic [DEPTH-1:0][31:0] datas,
    input  logic [PW-1:0]          head,
    input  logic [CW-1:0]          count,
    input  logic [4:0]             rd_addr,
    output logic                   hit,
    output logic [31:0]            fwd
);

    logic [PW-1:0] idx;

    // Walk from oldest to youngest so the last match seen is the youngest.
    always_comb begin
        // NOTE: every output gets a default before the loop so no path leaves it unassigned (no latch).
        hit = 1'b0;
        fwd = '0;
        idx = '0;
        for (int i = 0; i < DEPTH; i++) begin
            idx = head + PW'(i);
            if ((i < int'(count)) && is_live(rd_addr) && (addrs[idx] == rd_addr)) begin
                hit = 1'b1;
                fwd = datas[idx];
            end
        end
    end

endmodule

// File: rtl/grf_wb_arbiter.sv
// Two-port write-back arbiter feeding the GRF write port through an in-order queue.
module grf_wb_arbiter
    import grf_wb_pkg::*;
#(
    parameter int DEPTH = DEFAULT_DEPTH
) (
    input  logic     Clk,
    input  logic     Reset,
    grf_wb_if.slave  bus
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    wb_entry_t     mem_q [DEPTH];
    logic [PW-1:0] head_q, head_d;
    logic [PW-1:0] tail_q, tail_d;
    logic [CW-1:0] count_q, count_d;

    logic [CW-1:0] free;
    logic [CW-1:0] need1;
    logic          rdy0, rdy1;
    logic          acc0, acc1;
    logic          pop;
    logic [PW-1:0] wr1_idx;
    wb_entry_t     in0_entry, in1_entry, head_entry;

    logic [DEPTH-1:0][4:0]  addr_vec;
    logic [DEPTH-1:0][31:0] data_vec;

    // Admission: free space ignores this cycle's pop, and port 1 leaves room for a live port-0 write.
    always_comb begin
        free  = CW'(DEPTH) - count_q;
        need1 = CW'(1) + CW'(bus.in0_valid && is_live(bus.in0_addr));
        rdy0  = Reset && (free >= CW'(1));
        rdy1  = Reset && (free >= need1);
        acc0  = bus.in0_valid && rdy0 && is_live(bus.in0_addr);
        acc1  = bus.in1_valid && rdy1 && is_live(bus.in1_addr);
        in0_entry = '{pc: bus.in0_pc, addr: bus.in0_addr, data: bus.in0_data};
        in1_entry = '{pc: bus.in1_pc, addr: bus.in1_addr, data: bus.in1_data};
    end

    assign bus.in0_ready = rdy0;
    assign bus.in1_ready = rdy1;

    // Pointer and occupancy next-state; port 0 lands ahead of port 1.
    always_comb begin
        pop     = (count_q != '0);
        wr1_idx = tail_q + PW'(acc0);
        tail_d  = tail_q + PW'(acc0) + PW'(acc1);
        head_d  = head_q + PW'(pop);
        count_d = count_q + CW'(acc0) + CW'(acc1) - CW'(pop);
    end

    // Pointer and count registers with synchronous active-low clear.
    always_ff @(posedge Clk) begin
        // NOTE: non-blocking assignments so every flop samples pre-edge values regardless of statement order.
        if (!Reset) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // Entry storage writes for accepted live requests.
    always_ff @(posedge Clk) begin
        // NOTE: storage is not reset; count_q gates every read, so stale contents are never visible.
        if (acc0) mem_q[tail_q]  <= in0_entry;
        if (acc1) mem_q[wr1_idx] <= in1_entry;
    end

    // Commit the head entry and publish occupancy; outputs are zero while empty.
    always_comb begin
        head_entry = mem_q[head_q];
        bus.WE     = pop;
        bus.PC     = pop ? head_entry.pc   : '0;
        bus.A3     = pop ? head_entry.addr : REG_ZERO;
        bus.WD     = pop ? head_entry.data : '0;
        bus.count  = count_q;
        bus.full   = (count_q == CW'(DEPTH));
        bus.empty  = !pop;
    end

    // Flatten addresses and data for the lookup searches.
    always_comb begin
        addr_vec = '0;
        data_vec = '0;
        for (int i = 0; i < DEPTH; i++) begin
            addr_vec[i] = mem_q[i].addr;
            data_vec[i] = mem_q[i].data;
        end
    end

    grf_wb_match #(.DEPTH(DEPTH)) u_match1 (
        .addrs   (addr_vec),
        .datas   (data_vec),
        .head    (head_q),
        .count   (count_q),
        .rd_addr (bus.rd_a1),
        .hit     (bus.hit1),
        .fwd     (bus.fwd1)
    );

    grf_wb_match #(.DEPTH(DEPTH)) u_match2 (
        .addrs   (addr_vec),
        .datas   (data_vec),
        .head    (head_q),
        .count   (count_q),
        .rd_addr (bus.rd_a2),
        .hit     (bus.hit2),
        .fwd     (bus.fwd2)
    );

endmodule

// File: tb/tb_grf_wb_arbiter.sv
// Bench for grf_wb_arbiter: table-driven vectors plus multi-cycle sequences,
// with a queue scoreboard of expected GRF commits.
module tb_grf_wb_arbiter;
    import grf_wb_pkg::*;

    localparam int DEPTH = 4;

    logic Clk = 1'b0;
    logic Reset;
    always #5 Clk = ~Clk;

    grf_wb_if #(.DEPTH(DEPTH)) bus ();

    grf_wb_arbiter #(.DEPTH(DEPTH)) dut (
        .Clk   (Clk),
        .Reset (Reset),
        .bus   (bus)
    );

    typedef struct {
        logic        rst;
        logic        v0;
        logic [31:0] p0;
        logic [4:0]  a0;
        logic [31:0] d0;
        logic        v1;
        logic [31:0] p1;
        logic [4:0]  a1;
        logic [31:0] d1;
        logic [4:0]  r1;
        logic [4:0]  r2;
        bit          chk;
        logic        e_rdy0;
        logic        e_rdy1;
        logic [2:0]  e_cnt;
        logic        e_hit1;
        logic [31:0] e_fwd1;
    } vec_t;

    int        checks   = 0;
    int        failures = 0;
    int        dut_commits = 0;
    wb_entry_t sb[$];
    vec_t      tbl[11];
    bit        acc0_o, acc1_o;
    int        n0, n1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic vec_t mk(input logic rst,
                                input logic v0, input logic [4:0] a0, input logic [31:0] d0,
                                input logic v1, input logic [4:0] a1, input logic [31:0] d1,
                                input logic [4:0] r1, input logic [4:0] r2);
        vec_t v;
        v.rst = rst;
        v.v0 = v0; v.a0 = a0; v.d0 = d0; v.p0 = 32'h1000 ^ d0;
        v.v1 = v1; v.a1 = a1; v.d1 = d1; v.p1 = 32'h2000 ^ d1;
        v.r1 = r1; v.r2 = r2;
        v.chk = 1'b0;
        v.e_rdy0 = 1'b0; v.e_rdy1 = 1'b0; v.e_cnt = '0; v.e_hit1 = 1'b0; v.e_fwd1 = '0;
        return v;
    endfunction

    function automatic vec_t with_exp(input vec_t v, input logic r0, input logic r1,
                                      input logic [2:0] cnt, input logic h, input logic [31:0] f);
        vec_t o;
        o = v;
        o.chk = 1'b1;
        o.e_rdy0 = r0; o.e_rdy1 = r1; o.e_cnt = cnt; o.e_hit1 = h; o.e_fwd1 = f;
        return o;
    endfunction

    function automatic vec_t idle(input logic [4:0] r1, input logic [4:0] r2);
        return mk(1'b1, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, r1, r2);
    endfunction

    // Youngest queued write to a nonzero register, taken from the scoreboard.
    function automatic void lookup(input logic [4:0] a, output logic hit, output logic [31:0] d);
        hit = 1'b0;
        d   = '0;
        if (a != 5'd0) begin
            for (int i = 0; i < sb.size(); i++) begin
                if (sb[i].addr == a) begin
                    hit = 1'b1;
                    d   = sb[i].data;
                end
            end
        end
    endfunction

    // One clock cycle: drive at negedge, compare before posedge, then advance the model.
    task automatic step(input vec_t v, output bit acc0, output bit acc1);
        int          sz;
        logic        e_r0, e_r1, h;
        logic [31:0] f;
        wb_entry_t   hd;
        Reset         = v.rst;
        bus.in0_valid = v.v0; bus.in0_pc = v.p0; bus.in0_addr = v.a0; bus.in0_data = v.d0;
        bus.in1_valid = v.v1; bus.in1_pc = v.p1; bus.in1_addr = v.a1; bus.in1_data = v.d1;
        bus.rd_a1     = v.r1; bus.rd_a2 = v.r2;
        #1;
        sz   = sb.size();
        e_r0 = v.rst && (sz < DEPTH);
        e_r1 = v.rst && ((DEPTH - sz) >= (1 + ((v.v0 && v.a0 != 5'd0) ? 1 : 0)));
        check("in0_ready", 32'(bus.in0_ready), 32'(e_r0));
        check("in1_ready", 32'(bus.in1_ready), 32'(e_r1));
        hd = (sz != 0) ? sb[0] : '0;
        check("WE", 32'(bus.WE), 32'(sz != 0));
        check("PC", bus.PC, hd.pc);
        check("A3", 32'(bus.A3), 32'(hd.addr));
        check("WD", bus.WD, hd.data);
        check("count", 32'(bus.count), 32'(sz));
        check("full", 32'(bus.full), 32'(sz == DEPTH));
        check("empty", 32'(bus.empty), 32'(sz == 0));
        lookup(v.r1, h, f);
        check("hit1", 32'(bus.hit1), 32'(h));
        check("fwd1", bus.fwd1, f);
        lookup(v.r2, h, f);
        check("hit2", 32'(bus.hit2), 32'(h));
        check("fwd2", bus.fwd2, f);
        if (v.chk) begin
            check("tbl_in0_ready", 32'(bus.in0_ready), 32'(v.e_rdy0));
            check("tbl_in1_ready", 32'(bus.in1_ready), 32'(v.e_rdy1));
            check("tbl_count", 32'(bus.count), 32'(v.e_cnt));
            check("tbl_hit1", 32'(bus.hit1), 32'(v.e_hit1));
            check("tbl_fwd1", bus.fwd1, v.e_fwd1);
        end
        if (bus.WE === 1'b1 && v.rst) dut_commits++;
        acc0 = 1'b0;
        acc1 = 1'b0;
        if (!v.rst) begin
            sb.delete();
        end else begin
            if (sz != 0) void'(sb.pop_front());
            acc0 = v.v0 && e_r0;
            acc1 = v.v1 && e_r1;
            if (acc0 && v.a0 != 5'd0) sb.push_back('{pc: v.p0, addr: v.a0, data: v.d0});
            if (acc1 && v.a1 != 5'd0) sb.push_back('{pc: v.p1, addr: v.a1, data: v.d1});
        end
        @(posedge Clk);
        @(negedge Clk);
    endtask

    task automatic drain(input string name);
        bit a0, a1;
        for (int c = 0; c < 12 && sb.size() != 0; c++) step(idle(5'd0, 5'd0), a0, a1);
        #1;
        check(name, 32'(bus.empty), 32'd1);
    endtask

    initial begin
        // Vector table: reset, single write latency, same-cycle pair, r0 discard.
        tbl[0]  = with_exp(mk(1'b0, 1'b1, 5'd8, 32'h11, 1'b0, 5'd0, 32'd0, 5'd8, 5'd0), 1'b0, 1'b0, 3'd0, 1'b0, 32'h0);
        tbl[1]  = tbl[0];
        tbl[2]  = with_exp(mk(1'b1, 1'b1, 5'd8, 32'h11, 1'b0, 5'd0, 32'd0, 5'd8, 5'd8), 1'b1, 1'b1, 3'd0, 1'b0, 32'h0);
        tbl[2].p0 = 32'h3000;
        tbl[3]  = with_exp(idle(5'd8, 5'd5), 1'b1, 1'b1, 3'd1, 1'b1, 32'h11);
        tbl[4]  = with_exp(idle(5'd8, 5'd0), 1'b1, 1'b1, 3'd0, 1'b0, 32'h0);
        tbl[5]  = with_exp(mk(1'b1, 1'b1, 5'd9, 32'hA, 1'b1, 5'd9, 32'hB, 5'd9, 5'd0), 1'b1, 1'b1, 3'd0, 1'b0, 32'h0);
        tbl[6]  = with_exp(idle(5'd9, 5'd9), 1'b1, 1'b1, 3'd2, 1'b1, 32'hB);
        tbl[7]  = with_exp(idle(5'd9, 5'd0), 1'b1, 1'b1, 3'd1, 1'b1, 32'hB);
        tbl[8]  = with_exp(idle(5'd9, 5'd0), 1'b1, 1'b1, 3'd0, 1'b0, 32'h0);
        tbl[9]  = with_exp(mk(1'b1, 1'b0, 5'd0, 32'd0, 1'b1, 5'd0, 32'hFF, 5'd0, 5'd0), 1'b1, 1'b1, 3'd0, 1'b0, 32'h0);
        tbl[10] = with_exp(idle(5'd0, 5'd0), 1'b1, 1'b1, 3'd0, 1'b0, 32'h0);

        Reset = 1'b0;
        bus.in0_valid = 1'b1; bus.in0_pc = '0; bus.in0_addr = 5'd8; bus.in0_data = 32'h11;
        bus.in1_valid = 1'b0; bus.in1_pc = '0; bus.in1_addr = '0; bus.in1_data = '0;
        bus.rd_a1 = '0; bus.rd_a2 = '0;
        @(negedge Clk);

        for (int i = 0; i < 11; i++) step(tbl[i], acc0_o, acc1_o);

        // Saturation: both producers stream and hold until accepted.
        n0 = 0;
        n1 = 0;
        for (int c = 0; c < 40 && (n0 < 6 || n1 < 6); c++) begin
            step(mk(1'b1, 1'(n0 < 6), 5'(1 + n0), 32'h100 + n0,
                          1'(n1 < 6), 5'(17 + n1), 32'h200 + n1, 5'(n0), 5'(16 + n1)),
                 acc0_o, acc1_o);
            if (acc0_o) n0++;
            if (acc1_o) n1++;
        end
        check("sat_all_sent", 32'(n0 + n1), 32'd12);
        drain("sat_drained");

        // Occupancy three: port 1 blocked by a live port 0, admitted when port 0 targets r0.
        step(mk(1'b1, 1'b1, 5'd3, 32'h31, 1'b1, 5'd4, 32'h41, 5'd0, 5'd0), acc0_o, acc1_o);
        step(mk(1'b1, 1'b1, 5'd5, 32'h51, 1'b1, 5'd6, 32'h61, 5'd3, 5'd4), acc0_o, acc1_o);
        step(with_exp(mk(1'b1, 1'b1, 5'd8, 32'h81, 1'b1, 5'd9, 32'h91, 5'd5, 5'd6),
                      1'b1, 1'b0, 3'd3, 1'b1, 32'h51), acc0_o, acc1_o);
        step(with_exp(mk(1'b1, 1'b1, 5'd0, 32'h77, 1'b1, 5'd9, 32'h91, 5'd8, 5'd0),
                      1'b1, 1'b1, 3'd3, 1'b1, 32'h81), acc0_o, acc1_o);
        drain("cnt3_drained");

        // Reset mid-operation with three entries queued.
        step(mk(1'b1, 1'b1, 5'd10, 32'hA1, 1'b1, 5'd11, 32'hB1, 5'd0, 5'd0), acc0_o, acc1_o);
        step(mk(1'b1, 1'b1, 5'd12, 32'hC1, 1'b1, 5'd13, 32'hD1, 5'd11, 5'd0), acc0_o, acc1_o);
        step(mk(1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 5'd11, 5'd13), acc0_o, acc1_o);
        step(with_exp(idle(5'd11, 5'd13), 1'b1, 1'b1, 3'd0, 1'b0, 32'h0), acc0_o, acc1_o);
        step(idle(5'd12, 5'd0), acc0_o, acc1_o);

        // Wrap-around: ten back-to-back single writes.
        for (int k = 1; k <= 10; k++) begin
            step(mk(1'b1, 1'b1, 5'(k), 32'hC00 + k, 1'b0, 5'd0, 32'd0, 5'(k), 5'(k - 1)),
                 acc0_o, acc1_o);
        end
        drain("wrap_drained");

        check("commit_total", 32'(dut_commits), 32'd32);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
